// File: rtl/calib_pkg.sv
// Shared types for the calibration LUT search: FSM states and search-mode encodings.
package calib_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PROBE,
    CMP,
    FETCH,
    LOAD,
    DONE
  } state_t;

  localparam logic MODE_BINARY = 1'b0;
  localparam logic MODE_LINEAR = 1'b1;

endpackage

// File: rtl/calibration_search_if.sv
// Request/result bus plus external ROM port of the calibration search.
interface calibration_search_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned POS_W  = 5
);
  logic                     start;
  logic                     mode;
  logic signed [DATA_W-1:0] X;
  logic        [POS_W-1:0]  lut_addr;
  logic signed [DATA_W-1:0] lut_data;
  logic                     ready;
  logic                     busy;
  logic        [POS_W-1:0]  pos;
  logic signed [DATA_W-1:0] Y;
  logic signed [DATA_W:0]   err;
  logic                     under;

  // System side: front end issuing requests and the ROM returning data
  modport master (
    output start, mode, X, lut_data,
    input  lut_addr, ready, busy, pos, Y, err, under
  );

  modport slave (
    input  start, mode, X, lut_data,
    output lut_addr, ready, busy, pos, Y, err, under
  );
endinterface

// File: rtl/calibration_search.sv
// Finds the largest entry <= X in a monotonic ROM LUT by binary or linear search,
// reporting index, entry value and full-precision residual.
module calibration_search
  import calib_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned POS_W  = 5
) (
  input logic                 clock,
  input logic                 reset,
  calibration_search_if.slave bus
);

  localparam logic [POS_W-1:0] POS_MAX = '1;
  localparam logic [POS_W-1:0] TOP_BIT = POS_W'(1) << (POS_W - 1);

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  x_q, x_d;
  logic                      mode_q, mode_d;
  logic        [POS_W-1:0]   acc_q, acc_d;
  logic        [POS_W-1:0]   mask_q, mask_d;
  logic        [POS_W-1:0]   addr_q, addr_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic        [POS_W-1:0]   pos_q, pos_d;
  logic signed [DATA_W-1:0]  y_q, y_d;
  logic signed [DATA_W:0]    err_q, err_d;
  logic                      under_q, under_d;

  logic                      le_c;
  logic                      last_c;
  logic        [POS_W-1:0]   acc_next_c;

  assign le_c = (bus.lut_data <= x_q);

  // Search step: accumulator update and whether this compare ends the probe loop
  always_comb begin
    acc_next_c = acc_q;
    last_c     = 1'b0;
    if (mode_q == MODE_BINARY) begin
      if (le_c) acc_next_c = addr_q;
      last_c = mask_q[0];
    end else begin
      if (!le_c) acc_next_c = (addr_q == '0) ? '0 : addr_q - POS_W'(1);
      else       acc_next_c = addr_q;
      last_c = !le_c || (addr_q == POS_MAX);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = PROBE;
      PROBE:   state_d = CMP;
      CMP:     state_d = last_c ? FETCH : PROBE;
      FETCH:   state_d = LOAD;
      LOAD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // lut_addr is loaded on entry to PROBE/FETCH so ROM data is valid during CMP/LOAD
  always_comb begin
    x_d     = x_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    pos_d   = pos_q;
    y_d     = y_q;
    err_d   = err_q;
    under_d = under_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.X;
          mode_d  = bus.mode;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          acc_d   = '0;
          mask_d  = TOP_BIT;
          addr_d  = (bus.mode == MODE_LINEAR) ? '0 : TOP_BIT;
        end
      end
      CMP: begin
        acc_d  = acc_next_c;
        mask_d = mask_q >> 1;
        if (last_c)                     addr_d = acc_next_c;
        else if (mode_q == MODE_BINARY) addr_d = acc_next_c | (mask_q >> 1);
        else                            addr_d = addr_q + POS_W'(1);
      end
      LOAD: begin
        y_d     = bus.lut_data;
        pos_d   = acc_q;
        err_d   = {x_q[DATA_W-1], x_q} - {bus.lut_data[DATA_W-1], bus.lut_data};
        under_d = (acc_q == '0) && !le_c;
      end
      DONE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      mode_q  <= MODE_BINARY;
      acc_q   <= '0;
      mask_q  <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      pos_q   <= '0;
      y_q     <= '0;
      err_q   <= '0;
      under_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      pos_q   <= pos_d;
      y_q     <= y_d;
      err_q   <= err_d;
      under_q <= under_d;
    end
  end

  assign bus.lut_addr = addr_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.pos      = pos_q;
  assign bus.Y        = y_q;
  assign bus.err      = err_q;
  assign bus.under    = under_q;

endmodule

// File: tb/tb_calibration_search.sv
// Self-checking bench for calibration_search: spec vectors, corner sequences and
// randomized LUT/sample runs against a behavioural model.
module tb_calibration_search;

  logic clock;
  logic reset;

  calibration_search_if #(.DATA_W(16), .POS_W(5)) bus ();

  calibration_search #(.DATA_W(16), .POS_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #25 clock = ~clock;

  // 1-cycle synchronous ROM model
  logic signed [15:0] mem [32];
  always_ff @(posedge clock) bus.lut_data <= mem[bus.lut_addr];

  int vectors;
  int miscompares;

  typedef struct {
    logic signed [15:0] x;
    logic               m;
    int                 pos;
    int                 y;
    int                 err;
    bit                 under;
    int                 lat;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mk(int x, bit m, int p, int y, int e, bit u, int l);
    vec_t v;
    v.x = 16'(x); v.m = m; v.pos = p; v.y = y; v.err = e; v.under = u; v.lat = l;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: largest index whose entry <= x; linear probe count from first entry > x
  task automatic model(input logic signed [15:0] x, input logic m,
                       output int p, output int y, output int e, output bit u, output int lat);
    int n;
    p = 0;
    for (int i = 0; i < 32; i++) if (mem[i] <= x) p = i;
    y = int'(mem[p]);
    e = int'(x) - y;
    u = (x < mem[0]);
    if (m == 1'b0) lat = 2 * 5 + 3;
    else begin
      n = 32;
      for (int i = 0; i < 32; i++) if (mem[i] > x) begin n = i + 1; break; end
      lat = 2 * n + 3;
    end
  endtask

  // Issue one request; lat counts rising edges from the sampling edge to ready (-1 on timeout)
  task automatic do_op(input logic signed [15:0] x, input logic m, output int lat);
    @(negedge clock);
    bus.start = 1'b1; bus.X = x; bus.mode = m;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.X = 16'($urandom);
    lat = 0;
    while (!bus.ready && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!bus.ready) lat = -1;
  endtask

  task automatic check_result(input string tag, input int lat, input int p, input int y,
                              input int e, input bit u, input int l);
    chk({tag, " latency"}, longint'(lat), longint'(l));
    chk({tag, " pos"},     longint'(bus.pos), longint'(p));
    chk({tag, " Y"},       longint'(bus.Y), longint'(y));
    chk({tag, " err"},     longint'(bus.err), longint'(e));
    chk({tag, " under"},   longint'(bus.under), longint'(u));
    chk({tag, " busy"},    longint'(bus.busy), 0);
  endtask

  task automatic load_spec_lut();
    for (int i = 0; i < 32; i++) mem[i] = 16'(100 * i - 1000);
  endtask

  initial begin
    int lat, p, y, e, l, base;
    bit u;
    logic signed [15:0] x;
    logic m;

    vectors = 0; miscompares = 0;
    bus.start = 1'b0; bus.mode = 1'b0; bus.X = '0;
    load_spec_lut();
    reset = 1'b1;

    tbl[0]  = mk(0,      0, 10,     0,      0, 0, 13);
    tbl[1]  = mk(-1,     0,  9,  -100,     99, 0, 13);
    tbl[2]  = mk(-2000,  0,  0, -1000,  -1000, 1, 13);
    tbl[3]  = mk(5000,   0, 31,  2100,   2900, 0, 13);
    tbl[4]  = mk(0,      1, 10,     0,      0, 0, 27);
    tbl[5]  = mk(5000,   1, 31,  2100,   2900, 0, 67);
    tbl[6]  = mk(-32768, 0,  0, -1000, -31768, 1, 13);
    tbl[7]  = mk(-32768, 1,  0, -1000, -31768, 1,  5);
    tbl[8]  = mk(2100,   0, 31,  2100,      0, 0, 13);
    tbl[9]  = mk(-1000,  1,  0, -1000,      0, 0,  7);
    tbl[10] = mk(32767,  1, 31,  2100,  30667, 0, 67);

    repeat (3) @(posedge clock);
    #1;
    chk("reset ready",    longint'(bus.ready), 0);
    chk("reset busy",     longint'(bus.busy), 0);
    chk("reset pos",      longint'(bus.pos), 0);
    chk("reset Y",        longint'(bus.Y), 0);
    chk("reset err",      longint'(bus.err), 0);
    chk("reset under",    longint'(bus.under), 0);
    chk("reset lut_addr", longint'(bus.lut_addr), 0);
    @(negedge clock) reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_op(tbl[i].x, tbl[i].m, lat);
      check_result($sformatf("vec%0d", i), lat, tbl[i].pos, tbl[i].y, tbl[i].err,
                   tbl[i].under, tbl[i].lat);
    end

    // Start pulsed while busy must be dropped
    @(negedge clock);
    bus.start = 1'b1; bus.X = 16'sd0; bus.mode = 1'b0;
    @(posedge clock); #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.ready && lat < 200) begin
      if (lat == 3) begin bus.start = 1'b1; bus.X = -16'sd2000; end
      else bus.start = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
    bus.start = 1'b0;
    if (!bus.ready) lat = -1;
    check_result("ignored-start", lat, 10, 0, 0, 0, 13);
    repeat (6) @(posedge clock);
    #1;
    chk("ignored-start idle busy",  longint'(bus.busy), 0);
    chk("ignored-start idle ready", longint'(bus.ready), 1);
    chk("ignored-start idle pos",   longint'(bus.pos), 10);

    // Back-to-back: second start lands in the IDLE cycle right after DONE
    do_op(-16'sd1, 1'b0, lat);
    check_result("b2b first", lat, 9, -100, 99, 0, 13);
    do_op(16'sd0, 1'b1, lat);
    check_result("b2b second", lat, 10, 0, 0, 0, 27);

    // Asynchronous reset mid-search
    @(negedge clock);
    bus.start = 1'b1; bus.X = -16'sd2000; bus.mode = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midreset ready",    longint'(bus.ready), 0);
    chk("midreset busy",     longint'(bus.busy), 0);
    chk("midreset pos",      longint'(bus.pos), 0);
    chk("midreset Y",        longint'(bus.Y), 0);
    chk("midreset err",      longint'(bus.err), 0);
    chk("midreset under",    longint'(bus.under), 0);
    chk("midreset lut_addr", longint'(bus.lut_addr), 0);
    @(negedge clock) reset = 1'b0;
    do_op(16'sd0, 1'b0, lat);
    check_result("after-reset", lat, 10, 0, 0, 0, 13);

    // Randomized monotonic LUTs (with repeated entries) and samples
    for (int t = 0; t < 4; t++) begin
      base = -20000 + int'($urandom_range(0, 10000));
      for (int i = 0; i < 32; i++) begin
        mem[i] = 16'(base);
        base += int'($urandom_range(0, 1200));
      end
      for (int k = 0; k < 12; k++) begin
        if ($urandom_range(0, 1) == 0) x = 16'($urandom);
        else x = 16'(int'(mem[$urandom_range(0, 31)]) + int'($urandom_range(0, 2)) - 1);
        m = 1'($urandom_range(0, 1));
        model(x, m, p, y, e, u, l);
        do_op(x, m, lat);
        check_result($sformatf("rand t%0d k%0d x=%0d m=%0d", t, k, x, m), lat, p, y, e, u, l);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
